stage_mem: RTL and testbench

//  Memory-access pipeline stage directly downstream of the execute stage. Consumes the EX result
//  (effective address / ALU value) and store data (X[RS2]), runs one load/store on the data bus

---
 rtl/stage_mem_pkg.sv | 18 +
 rtl/stage_mem_align.sv | 46 ++++
 rtl/stage_mem.sv | 134 +++++++++++++
 tb/tb_stage_mem.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared types for the memory-access pipeline stage.
package stage_mem_pkg;
  localparam int BYTE_EN_WIDTH = 4;

  typedef enum logic [2:0] {
    MemAccess_B  = 3'b000,
    MemAccess_H  = 3'b001,
    MemAccess_W  = 3'b010,
    MemAccess_BU = 3'b100,
    MemAccess_HU = 3'b101
  } MemAccess;

  typedef enum logic [1:0] {
    MemState_IDLE = 2'd0,
    MemState_WAIT = 2'd1,
    MemState_DONE = 2'd2
  } MemState;
endpackage

// File: rtl/stage_mem_align.sv
// Store lane/strobe generation, misalignment detect and load extract/extend.
module mem_data_align
  import stage_mem_pkg::*;
(
  input  logic [1:0]               stOff,
  input  MemAccess                 stAccess,
  input  logic [31:0]              stData,
  output logic [BYTE_EN_WIDTH-1:0] byteEn,
  output logic [31:0]              wrData,
  output logic                     misaligned,
  input  logic [1:0]               ldOff,
  input  MemAccess                 ldAccess,
  input  logic [31:0]              rdData,
  output logic [31:0]              ldData
);
  logic [31:0] ldShift;

  always_comb begin
    byteEn     = '1;
    wrData     = stData;
    misaligned = 1'b0;
    case (stAccess)
      MemAccess_B, MemAccess_BU: begin
        byteEn = 4'b0001 << stOff;
        wrData = {4{stData[7:0]}};
      end
      MemAccess_H, MemAccess_HU: begin
        byteEn     = 4'b0011 << {stOff[1], 1'b0};
        wrData     = {2{stData[15:0]}};
        misaligned = stOff[0];
      end
      default: misaligned = |stOff;
    endcase
  end

  always_comb begin
    ldShift = rdData >> {ldOff, 3'b000};
    case (ldAccess)
      MemAccess_B:  ldData = {{24{ldShift[7]}}, ldShift[7:0]};
      MemAccess_BU: ldData = {24'b0, ldShift[7:0]};
      MemAccess_H:  ldData = {{16{ldShift[15]}}, ldShift[15:0]};
      MemAccess_HU: ldData = {16'b0, ldShift[15:0]};
      default:      ldData = ldShift;
    endcase
  end
endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: one load/store per op over a req/ack bus, stalling the pipe meanwhile.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_isValid,
  input  logic [31:0]              i_dataR,
  input  logic [31:0]              i_dataB,
  input  logic                     i_memRd,
  input  logic                     i_memWr,
  input  MemAccess                 i_memAccess,
  output logic [31:0]              o_memAddr,
  output logic [31:0]              o_memWrData,
  output logic [BYTE_EN_WIDTH-1:0] o_memByteEn,
  output logic                     o_memWr,
  output logic                     o_memReq,
  input  logic                     i_memAck,
  input  logic [31:0]              i_memRdData,
  output logic                     o_hazard,
  output logic [31:0]              o_dataR,
  output logic                     o_misaligned,
  output logic                     o_busError,
  output logic                     o_evMemRead,
  output logic                     o_evMemWrite
);
  MemState                  state, nextState;
  logic [31:0]              addrQ, wrDataQ, rdDataQ, tmoCnt;
  logic [1:0]               offQ;
  logic [BYTE_EN_WIDTH-1:0] enQ, stEn;
  MemAccess                 accessQ;
  logic                     isWrQ, errQ;
  logic [31:0]              stWrData, ldData;
  logic                     stMis, memOp, timedOut;

  assign memOp    = i_isValid & (i_memRd | i_memWr);
  assign timedOut = (TIMEOUT > 0) && (tmoCnt == 32'(TIMEOUT - 1));

  mem_data_align uAlign (
    .stOff     (i_dataR[1:0]),
    .stAccess  (i_memAccess),
    .stData    (i_dataB),
    .byteEn    (stEn),
    .wrData    (stWrData),
    .misaligned(stMis),
    .ldOff     (offQ),
    .ldAccess  (accessQ),
    .rdData    (rdDataQ),
    .ldData    (ldData)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= MemState_IDLE;
      addrQ   <= '0;
      offQ    <= '0;
      enQ     <= '0;
      wrDataQ <= '0;
      accessQ <= MemAccess_B;
      isWrQ   <= 1'b0;
      rdDataQ <= '0;
      tmoCnt  <= '0;
      errQ    <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        MemState_IDLE: if (memOp && !stMis) begin
          addrQ   <= {i_dataR[31:2], 2'b00};
          offQ    <= i_dataR[1:0];
          enQ     <= stEn;
          wrDataQ <= stWrData;
          accessQ <= i_memAccess;
          isWrQ   <= i_memWr;
          rdDataQ <= '0;
          tmoCnt  <= '0;
          errQ    <= 1'b0;
        end
        MemState_WAIT: begin
          if (i_memAck) rdDataQ <= i_memRdData;
          else begin
            tmoCnt <= tmoCnt + 32'd1;
            if (timedOut) errQ <= 1'b1;
          end
        end
        default: errQ <= 1'b0;
      endcase
    end
  end

  // A timed-out transfer still passes through DONE so the pipe sees a single release cycle.
  always_comb begin
    nextState    = state;
    o_hazard     = 1'b0;
    o_misaligned = 1'b0;
    o_dataR      = i_dataR;
    o_memReq     = 1'b0;
    o_memWr      = 1'b0;
    o_memByteEn  = '0;
    o_evMemRead  = 1'b0;
    o_evMemWrite = 1'b0;
    case (state)
      MemState_IDLE: if (memOp) begin
        if (stMis) begin
          o_misaligned = 1'b1;
          o_dataR      = '0;
        end else begin
          o_hazard  = 1'b1;
          nextState = MemState_WAIT;
        end
      end
      MemState_WAIT: begin
        o_memReq    = 1'b1;
        o_memWr     = isWrQ;
        o_memByteEn = enQ;
        o_hazard    = 1'b1;
        o_dataR     = '0;
        if (i_memAck || timedOut) nextState = MemState_DONE;
      end
      MemState_DONE: begin
        nextState = MemState_IDLE;
        if (!isWrQ) o_dataR = ldData;
        o_evMemRead  = ~isWrQ & ~errQ;
        o_evMemWrite = isWrQ & ~errQ;
      end
      default: nextState = MemState_IDLE;
    endcase
  end

  assign o_memAddr   = addrQ;
  assign o_memWrData = wrDataQ;
  assign o_busError  = (state == MemState_DONE) & errQ;
endmodule

// File: tb/tb_stage_mem.sv
// Directed table-driven bench for stage_mem, plus timeout and reset-in-WAIT sequences.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic        clk = 1'b0, rstN = 1'b0;
  logic        isValid = 1'b0, memRd = 1'b0, memWr = 1'b0, memAck = 1'b0;
  logic [31:0] dataR = '0, dataB = '0, memRdData = '0;
  MemAccess    memAccess = MemAccess_W;
  logic [31:0] memAddr, memWrData, outR;
  logic [3:0]  memByteEn;
  logic        oMemWr, memReq, hazard, misaligned, busError, evRd, evWr;

  int nVec = 0, nErr = 0;

  stage_mem #(.TIMEOUT(4)) dut (
    .i_clock(clk), .i_reset(rstN), .i_isValid(isValid), .i_dataR(dataR), .i_dataB(dataB),
    .i_memRd(memRd), .i_memWr(memWr), .i_memAccess(memAccess),
    .o_memAddr(memAddr), .o_memWrData(memWrData), .o_memByteEn(memByteEn), .o_memWr(oMemWr),
    .o_memReq(memReq), .i_memAck(memAck), .i_memRdData(memRdData), .o_hazard(hazard),
    .o_dataR(outR), .o_misaligned(misaligned), .o_busError(busError),
    .o_evMemRead(evRd), .o_evMemWrite(evWr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    MemAccess    acc;
    logic [31:0] addr;
    logic [31:0] b;
    logic [31:0] rdData;
    logic [3:0]  en;
    logic [31:0] wd;
    logic        mis;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, MemAccess_W,  32'h1000, 32'h11223344, 32'h0, 4'hF, 32'h11223344, 1'b0, 32'h1000};
    vecs[1]  = '{1'b0, 1'b1, MemAccess_B,  32'h1003, 32'h000000AB, 32'h0, 4'h8, 32'hABABABAB, 1'b0, 32'h1003};
    vecs[2]  = '{1'b0, 1'b1, MemAccess_H,  32'h1002, 32'h00005678, 32'h0, 4'hC, 32'h56785678, 1'b0, 32'h1002};
    vecs[3]  = '{1'b0, 1'b1, MemAccess_B,  32'h1001, 32'hFFFFFF5A, 32'h0, 4'h2, 32'h5A5A5A5A, 1'b0, 32'h1001};
    vecs[4]  = '{1'b1, 1'b0, MemAccess_B,  32'h1002, 32'h0, 32'h0080FF00, 4'h0, 32'h0, 1'b0, 32'hFFFFFF80};
    vecs[5]  = '{1'b1, 1'b0, MemAccess_BU, 32'h1002, 32'h0, 32'h0080FF00, 4'h0, 32'h0, 1'b0, 32'h00000080};
    vecs[6]  = '{1'b1, 1'b0, MemAccess_H,  32'h1002, 32'h0, 32'h0080FF00, 4'h0, 32'h0, 1'b0, 32'h00000080};
    vecs[7]  = '{1'b1, 1'b0, MemAccess_H,  32'h1000, 32'h0, 32'h1234FFEE, 4'h0, 32'h0, 1'b0, 32'hFFFFFFEE};
    vecs[8]  = '{1'b1, 1'b0, MemAccess_HU, 32'h1000, 32'h0, 32'h1234FFEE, 4'h0, 32'h0, 1'b0, 32'h0000FFEE};
    vecs[9]  = '{1'b1, 1'b0, MemAccess_W,  32'h1004, 32'h0, 32'hDEADBEEF, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 1'b0, MemAccess_B,  32'h1003, 32'h0, 32'h7F000000, 4'h0, 32'h0, 1'b0, 32'h0000007F};
    vecs[11] = '{1'b1, 1'b0, MemAccess_W,  32'h1002, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, MemAccess_H,  32'h1001, 32'h1234, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 1'b0, MemAccess_HU, 32'h1003, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 1'b1, MemAccess_W,  32'h1001, 32'h55, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0};

    // reset state
    #12;
    chk("rst memReq", 32'(memReq), 0);
    chk("rst byteEn", 32'(memByteEn), 0);
    chk("rst memWr", 32'(oMemWr), 0);
    chk("rst busError", 32'(busError), 0);
    rstN = 1'b1;
    tick();

    // pass-through when no memory op
    isValid = 1'b1; dataR = 32'hCAFEF00D; #1;
    chk("nop hazard", 32'(hazard), 0);
    chk("nop dataR", outR, 32'hCAFEF00D);
    chk("nop memReq", 32'(memReq), 0);
    isValid = 1'b0;

    foreach (vecs[i]) begin
      tick();
      isValid = 1'b1; memRd = vecs[i].rd; memWr = vecs[i].wr; memAccess = vecs[i].acc;
      dataR = vecs[i].addr; dataB = vecs[i].b; #1;
      chk($sformatf("v%0d misaligned", i), 32'(misaligned), 32'(vecs[i].mis));
      chk($sformatf("v%0d idle hazard", i), 32'(hazard), 32'(!vecs[i].mis));
      if (vecs[i].mis) begin
        chk($sformatf("v%0d mis dataR", i), outR, 0);
        tick();
        chk($sformatf("v%0d mis memReq", i), 32'(memReq), 0);
        isValid = 1'b0; memRd = 1'b0; memWr = 1'b0;
      end else begin
        tick();
        chk($sformatf("v%0d wait memReq", i), 32'(memReq), 1);
        chk($sformatf("v%0d wait hazard", i), 32'(hazard), 1);
        chk($sformatf("v%0d addr", i), memAddr, vecs[i].addr & 32'hFFFFFFFC);
        chk($sformatf("v%0d memWr", i), 32'(oMemWr), 32'(vecs[i].wr));
        if (vecs[i].wr) begin
          chk($sformatf("v%0d byteEn", i), 32'(memByteEn), 32'(vecs[i].en));
          chk($sformatf("v%0d wrData", i), memWrData, vecs[i].wd);
        end
        memAck = 1'b1; memRdData = vecs[i].rdData;
        tick();
        memAck = 1'b0; memRdData = 32'hBAD0BAD0;
        chk($sformatf("v%0d done hazard", i), 32'(hazard), 0);
        chk($sformatf("v%0d done memReq", i), 32'(memReq), 0);
        chk($sformatf("v%0d dataR", i), outR, vecs[i].r);
        chk($sformatf("v%0d evRead", i), 32'(evRd), 32'(vecs[i].rd));
        chk($sformatf("v%0d evWrite", i), 32'(evWr), 32'(vecs[i].wr));
        tick();
        isValid = 1'b0; memRd = 1'b0; memWr = 1'b0; #1;
        chk($sformatf("v%0d idle ev", i), 32'({evRd, evWr}), 0);
      end
    end

    // timeout: no ack for 4 WAIT cycles
    tick();
    isValid = 1'b1; memRd = 1'b1; memAccess = MemAccess_W; dataR = 32'h2000;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("tmo wait%0d memReq", c), 32'(memReq), 1);
      chk($sformatf("tmo wait%0d busError", c), 32'(busError), 0);
      tick();
    end
    chk("tmo busError", 32'(busError), 1);
    chk("tmo memReq", 32'(memReq), 0);
    chk("tmo dataR", outR, 0);
    chk("tmo hazard", 32'(hazard), 0);
    tick();
    isValid = 1'b0; memRd = 1'b0;
    memAck = 1'b1; memRdData = 32'h12345678;
    tick();
    memAck = 1'b0;
    chk("tmo late ack memReq", 32'(memReq), 0);
    chk("tmo late ack ev", 32'({evRd, busError}), 0);
    chk("tmo late ack hazard", 32'(hazard), 0);

    // reset asserted in WAIT
    tick();
    isValid = 1'b1; memRd = 1'b1; memAccess = MemAccess_W; dataR = 32'h3000;
    tick();
    chk("rstw memReq before", 32'(memReq), 1);
    #2 rstN = 1'b0; #1;
    chk("rstw memReq async", 32'(memReq), 0);
    isValid = 1'b0; memRd = 1'b0;
    tick();
    rstN = 1'b1;
    memAck = 1'b1; memRdData = 32'hFFFFFFFF;
    tick();
    memAck = 1'b0;
    chk("rstw post ack memReq", 32'(memReq), 0);
    chk("rstw post ack evRead", 32'(evRd), 0);
    chk("rstw post ack dataR", outR, 32'h3000);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
